// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: extends the instruction immediate by format and registers it.
// The output register plus a one-entry skid register give full throughput with a registered in_ready.
module imm_gen_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] extimm,
  output logic [TAG_W-1:0] out_tag,
  output logic             err
);

  // Sign-extended formats are assembled as a 32-bit value and then widened with a signed cast.
  function automatic logic [WIDTH-1:0] extend_imm(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0]      s32;
    logic [WIDTH-1:0] imm;
    logic             sext;
    s32  = 32'h0000_0000;
    imm  = {WIDTH{1'b0}};
    sext = 1'b0;
    case (sel)
      3'b000: begin s32 = {{20{ins[31]}}, ins[31:20]}; sext = 1'b1; end
      3'b001: begin s32 = {{20{ins[31]}}, ins[31:25], ins[11:7]}; sext = 1'b1; end
      3'b010: begin s32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; sext = 1'b1; end
      3'b011: begin s32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; sext = 1'b1; end
      3'b100: begin s32 = {ins[31:12], 12'h000}; sext = 1'b1; end
      3'b101: imm = (WIDTH == 64) ? WIDTH'(ins[25:20]) : WIDTH'(ins[24:20]);
      3'b110: imm = WIDTH'(ins[19:15]);
      default: imm = {WIDTH{1'b0}};
    endcase
    if (sext) begin
      imm = WIDTH'($signed(s32));
    end else begin
      imm = imm;
    end
    return imm;
  endfunction

  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_imm_r;
  logic [TAG_W-1:0] skid_tag_r;
  logic             skid_err_r;

  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [WIDTH-1:0] new_imm_s;
  logic             new_err_s;
  logic             out_valid_s;
  logic             skid_valid_s;
  logic             load_o_in_s;
  logic             load_o_skid_s;
  logic             load_k_s;

  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;
  assign new_imm_s  = extend_imm(instr, immsrc);
  assign new_err_s  = (immsrc == 3'b111);

  // Next-state selection for the output (O) and skid (K) entries.
  always_comb begin
    out_valid_s   = out_valid;
    skid_valid_s  = skid_valid_r;
    load_o_in_s   = 1'b0;
    load_o_skid_s = 1'b0;
    load_k_s      = 1'b0;
    if (flush) begin
      // An output transfer on this edge still counts; an input transfer is dropped.
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
    end else if (skid_valid_r) begin
      if (out_xfer_s) begin
        load_o_skid_s = 1'b1;
        out_valid_s   = 1'b1;
        skid_valid_s  = 1'b0;
      end else begin
        out_valid_s = out_valid;
      end
    end else if (in_xfer_s) begin
      if (!out_valid || out_xfer_s) begin
        load_o_in_s = 1'b1;
        out_valid_s = 1'b1;
      end else begin
        load_k_s     = 1'b1;
        skid_valid_s = 1'b1;
      end
    end else if (out_xfer_s) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid;
    end
  end

  // State registers; invalidated entries keep their data fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid    <= 1'b0;
      extimm       <= {WIDTH{1'b0}};
      out_tag      <= {TAG_W{1'b0}};
      err          <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_imm_r   <= {WIDTH{1'b0}};
      skid_tag_r   <= {TAG_W{1'b0}};
      skid_err_r   <= 1'b0;
      in_ready     <= 1'b0;
    end else begin
      out_valid    <= out_valid_s;
      skid_valid_r <= skid_valid_s;
      in_ready     <= ~skid_valid_s;
      if (load_o_in_s) begin
        extimm  <= new_imm_s;
        out_tag <= in_tag;
        err     <= new_err_s;
      end else if (load_o_skid_s) begin
        extimm  <= skid_imm_r;
        out_tag <= skid_tag_r;
        err     <= skid_err_r;
      end
      if (load_k_s) begin
        skid_imm_r <= new_imm_s;
        skid_tag_r <= in_tag;
        skid_err_r <= new_err_s;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32- and 64-bit instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [4:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] extimm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] extimm64;
  logic [4:0]  out_tag64;

  int checks = 0;
  int failures = 0;

  imm_gen_pipe #(.WIDTH(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .extimm(extimm32), .out_tag(out_tag32), .err(err32)
  );

  imm_gen_pipe #(.WIDTH(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .extimm(extimm64), .out_tag(out_tag64), .err(err64)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] ins, input logic [4:0] tg);
    in_valid = v;
    immsrc   = src;
    instr    = ins;
    in_tag   = tg;
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [31:0] exp;
  } vec_t;

  vec_t stream[4];

  initial begin
    stream[0] = '{3'b001, 32'hFE512E23, 32'hFFFFFFFC};
    stream[1] = '{3'b010, 32'hFE000CE3, 32'hFFFFFFF8};
    stream[2] = '{3'b011, 32'h0010006F, 32'h00000800};
    stream[3] = '{3'b100, 32'h123450B7, 32'h12345000};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    #12;
    check_value("rst_in_ready", {63'd0, in_ready32}, 64'd0);
    check_value("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    check_value("rst_extimm", {32'd0, extimm32}, 64'd0);
    reset = 1'b0;
    step();
    check_value("rel_in_ready", {63'd0, in_ready32}, 64'd1);
    check_value("rel_out_valid", {63'd0, out_valid32}, 64'd0);

    // I-format, both widths
    drive(1'b1, 3'b000, 32'hFFF00093, 5'h01);
    step();
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    check_value("i_valid", {63'd0, out_valid32}, 64'd1);
    check_value("i_imm32", {32'd0, extimm32}, 64'h00000000FFFFFFFF);
    check_value("i_err", {63'd0, err32}, 64'd0);
    check_value("i_tag", {59'd0, out_tag32}, 64'd1);
    check_value("i_imm64", extimm64, 64'hFFFFFFFFFFFFFFFF);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream[i].src, stream[i].ins, 5'(i + 2));
      step();
      check_value($sformatf("str%0d_valid", i), {63'd0, out_valid32}, 64'd1);
      check_value($sformatf("str%0d_imm", i), {32'd0, extimm32}, {32'd0, stream[i].exp});
      check_value($sformatf("str%0d_tag", i), {59'd0, out_tag32}, 64'(i + 2));
      check_value($sformatf("str%0d_rdy", i), {63'd0, in_ready32}, 64'd1);
    end

    // 64-bit specific formats plus zero-extended ones
    drive(1'b1, 3'b100, 32'h800000B7, 5'h03);
    step();
    check_value("u64", extimm64, 64'hFFFFFFFF80000000);
    check_value("u32", {32'd0, extimm32}, 64'h0000000080000000);
    drive(1'b1, 3'b101, 32'h03F00013, 5'h04);
    step();
    check_value("shamt64", extimm64, 64'h3F);
    check_value("shamt32", {32'd0, extimm32}, 64'h1F);
    drive(1'b1, 3'b110, 32'h800F8073, 5'h05);
    step();
    check_value("zimm32", {32'd0, extimm32}, 64'h1F);
    check_value("zimm64", extimm64, 64'h1F);

    // illegal format then legal
    drive(1'b1, 3'b111, 32'hFFFFFFFF, 5'h1A);
    step();
    check_value("ill_imm", {32'd0, extimm32}, 64'd0);
    check_value("ill_err", {63'd0, err32}, 64'd1);
    check_value("ill_tag", {59'd0, out_tag32}, 64'h1A);
    check_value("ill_err64", {63'd0, err64}, 64'd1);
    drive(1'b1, 3'b000, 32'h00500093, 5'h06);
    step();
    check_value("leg_imm", {32'd0, extimm32}, 64'd5);
    check_value("leg_err", {63'd0, err32}, 64'd0);
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    step();
    check_value("drain_valid", {63'd0, out_valid32}, 64'd0);

    // back-pressure: two entries fill O and K
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00100093, 5'h07);
    step();
    check_value("bp_a_imm", {32'd0, extimm32}, 64'd1);
    check_value("bp_a_rdy", {63'd0, in_ready32}, 64'd1);
    drive(1'b1, 3'b000, 32'h00200093, 5'h08);
    step();
    check_value("bp_b_rdy", {63'd0, in_ready32}, 64'd0);
    check_value("bp_b_imm", {32'd0, extimm32}, 64'd1);
    check_value("bp_b_tag", {59'd0, out_tag32}, 64'd7);
    drive(1'b1, 3'b000, 32'h00300093, 5'h09);
    step();
    check_value("bp_hold_imm", {32'd0, extimm32}, 64'd1);
    check_value("bp_hold_tag", {59'd0, out_tag32}, 64'd7);
    check_value("bp_hold_rdy", {63'd0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    step();
    check_value("bp_k2o_imm", {32'd0, extimm32}, 64'd2);
    check_value("bp_k2o_tag", {59'd0, out_tag32}, 64'd8);
    check_value("bp_k2o_rdy", {63'd0, in_ready32}, 64'd1);
    step();
    check_value("bp_c_imm", {32'd0, extimm32}, 64'd3);
    check_value("bp_c_tag", {59'd0, out_tag32}, 64'd9);
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    step();
    check_value("bp_empty", {63'd0, out_valid32}, 64'd0);

    // flush with O and K full
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00A00093, 5'h0A);
    step();
    drive(1'b1, 3'b000, 32'h00B00093, 5'h0B);
    step();
    check_value("fl_full_rdy", {63'd0, in_ready32}, 64'd0);
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'h00C00093, 5'h0C);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    check_value("fl_valid", {63'd0, out_valid32}, 64'd0);
    check_value("fl_rdy", {63'd0, in_ready32}, 64'd1);
    step();
    check_value("fl_after_valid", {63'd0, out_valid32}, 64'd0);

    // flush with an accepted input: input dropped
    drive(1'b1, 3'b000, 32'h00D00093, 5'h0D);
    step();
    check_value("fl2_loaded", {63'd0, out_valid32}, 64'd1);
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'h00E00093, 5'h0E);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    check_value("fl2_valid", {63'd0, out_valid32}, 64'd0);
    check_value("fl2_rdy", {63'd0, in_ready32}, 64'd1);
    step();
    check_value("fl2_dropped", {63'd0, out_valid32}, 64'd0);

    // asynchronous reset mid-stream
    drive(1'b1, 3'b000, 32'hFFF00093, 5'h0F);
    step();
    drive(1'b0, 3'b000, 32'h0, 5'h0);
    check_value("ar_pre_valid", {63'd0, out_valid32}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_value("ar_valid", {63'd0, out_valid32}, 64'd0);
    check_value("ar_imm", {32'd0, extimm32}, 64'd0);
    check_value("ar_tag", {59'd0, out_tag32}, 64'd0);
    check_value("ar_rdy", {63'd0, in_ready32}, 64'd0);
    check_value("ar_imm64", extimm64, 64'd0);
    reset = 1'b0;
    step();
    check_value("ar_rel_rdy", {63'd0, in_ready32}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
